// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one shift-add multiplier
// between requesters A and B, with a watchdog on the multiplier Done.
module mult_share_arbiter #(
   parameter int WIDTH   = 4,
   parameter int TIMEOUT = 32,
   parameter int CNT_W   = 8
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               A_Req,
   input  logic [WIDTH-1:0]   A_Q,
   input  logic [WIDTH-1:0]   A_R,
   output logic               A_Done,
   output logic [2*WIDTH-1:0] A_P,
   output logic               A_Err,
   input  logic               A_Ack,
   input  logic               B_Req,
   input  logic [WIDTH-1:0]   B_Q,
   input  logic [WIDTH-1:0]   B_R,
   output logic               B_Done,
   output logic [2*WIDTH-1:0] B_P,
   output logic               B_Err,
   input  logic               B_Ack,
   output logic               M_Start,
   output logic [WIDTH-1:0]   M_Q,
   output logic [WIDTH-1:0]   M_R,
   input  logic [2*WIDTH-1:0] M_P,
   input  logic               M_Done,
   output logic               M_Ack,
   output logic               Busy,
   output logic               Last_Grant
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LAUNCH  = 3'd1,
      WAIT    = 3'd2,
      RELEASE = 3'd3,
      RESP    = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   state_t             r_state, w_state;
   logic [CNT_W-1:0]   r_cnt, w_cnt;
   logic               r_gnt, w_gnt;
   logic               r_last, w_last;
   logic               r_to, w_to;
   logic               r_start, w_start;
   logic               r_ack, w_ack;
   logic               r_busy, w_busy;
   logic [WIDTH-1:0]   r_mq, w_mq;
   logic [WIDTH-1:0]   r_mr, w_mr;
   logic               r_a_done, w_a_done;
   logic [2*WIDTH-1:0] r_a_p, w_a_p;
   logic               r_a_err, w_a_err;
   logic               r_b_done, w_b_done;
   logic [2*WIDTH-1:0] r_b_p, w_b_p;
   logic               r_b_err, w_b_err;
   logic               w_pick_b;
   logic               w_x_ack;

   // Round-robin pick: B wins alone, or on a tie when A was served last.
   always_comb begin
      w_pick_b = B_Req & (~A_Req | ~r_last);
      w_x_ack  = r_gnt ? B_Ack : A_Ack;
   end

   // Next-state and next-output logic; every register holds by default.
   always_comb begin
      w_state  = r_state;
      w_cnt    = r_cnt;
      w_gnt    = r_gnt;
      w_last   = r_last;
      w_to     = r_to;
      w_start  = 1'b0;
      w_ack    = 1'b0;
      w_mq     = r_mq;
      w_mr     = r_mr;
      w_a_done = r_a_done;
      w_a_p    = r_a_p;
      w_a_err  = r_a_err;
      w_b_done = r_b_done;
      w_b_p    = r_b_p;
      w_b_err  = r_b_err;
      unique case (r_state)
         IDLE: begin
            if (A_Req | B_Req) begin
               w_gnt   = w_pick_b;
               w_mq    = w_pick_b ? B_Q : A_Q;
               w_mr    = w_pick_b ? B_R : A_R;
               w_cnt   = '0;
               w_to    = 1'b0;
               w_start = 1'b1;
               w_state = LAUNCH;
            end
         end
         LAUNCH: begin
            w_state = WAIT;
         end
         WAIT: begin
            if (M_Done) begin
               if (r_gnt) begin
                  w_b_p   = M_P;
                  w_b_err = 1'b0;
               end else begin
                  w_a_p   = M_P;
                  w_a_err = 1'b0;
               end
               w_to    = 1'b0;
               w_ack   = 1'b1;
               w_state = RELEASE;
            end else if (r_cnt == TO_LAST) begin
               if (r_gnt) begin
                  w_b_p   = '0;
                  w_b_err = 1'b1;
               end else begin
                  w_a_p   = '0;
                  w_a_err = 1'b1;
               end
               w_to    = 1'b1;
               w_ack   = 1'b1;
               w_state = RELEASE;
            end else begin
               w_cnt = r_cnt + CNT_W'(1);
            end
         end
         RELEASE: begin
            // Timed-out jobs get a single Ack cycle; normal jobs wait
            // for the multiplier to withdraw Done.
            if (r_to || !M_Done) begin
               if (r_gnt) w_b_done = 1'b1;
               else       w_a_done = 1'b1;
               w_state = RESP;
            end else begin
               w_ack = 1'b1;
            end
         end
         RESP: begin
            if (w_x_ack) begin
               w_a_done = 1'b0;
               w_b_done = 1'b0;
               w_last   = r_gnt;
               w_state  = IDLE;
            end
         end
         default: begin
            w_state = IDLE;
         end
      endcase
      w_busy = (w_state != IDLE);
   end

   // State and registered outputs; reset abandons any job in flight.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_gnt    <= 1'b0;
         r_last   <= 1'b1;
         r_to     <= 1'b0;
         r_start  <= 1'b0;
         r_ack    <= 1'b0;
         r_busy   <= 1'b0;
         r_mq     <= '0;
         r_mr     <= '0;
         r_a_done <= 1'b0;
         r_a_p    <= '0;
         r_a_err  <= 1'b0;
         r_b_done <= 1'b0;
         r_b_p    <= '0;
         r_b_err  <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_cnt    <= w_cnt;
         r_gnt    <= w_gnt;
         r_last   <= w_last;
         r_to     <= w_to;
         r_start  <= w_start;
         r_ack    <= w_ack;
         r_busy   <= w_busy;
         r_mq     <= w_mq;
         r_mr     <= w_mr;
         r_a_done <= w_a_done;
         r_a_p    <= w_a_p;
         r_a_err  <= w_a_err;
         r_b_done <= w_b_done;
         r_b_p    <= w_b_p;
         r_b_err  <= w_b_err;
      end
   end

   // Drive ports straight from registers.
   always_comb begin
      A_Done     = r_a_done;
      A_P        = r_a_p;
      A_Err      = r_a_err;
      B_Done     = r_b_done;
      B_P        = r_b_p;
      B_Err      = r_b_err;
      M_Start    = r_start;
      M_Q        = r_mq;
      M_R        = r_mr;
      M_Ack      = r_ack;
      Busy       = r_busy;
      Last_Grant = r_last;
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed checks of the shared-multiplier
// arbiter against a 6-cycle shift-add multiplier model.
module tb_mult_share_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       a_req = 0, b_req = 0, a_ack = 0, b_ack = 0;
   logic [3:0] a_q = 0, a_r = 0, b_q = 0, b_r = 0;
   logic       a_done, a_err, b_done, b_err;
   logic [7:0] a_p, b_p;
   logic       m_start, m_ack, busy, last_g;
   logic [3:0] m_q, m_r;
   logic [7:0] m_p = 0;
   logic       m_done = 0;
   logic       hang = 0;

   int checks = 0;
   int errors = 0;
   int n_start = 0, n_ack = 0, n_wait = 0;
   int s_start, s_ack, s_wait;

   logic [3:0] mq_l = 0, mr_l = 0;
   int         mcnt = 0;
   logic       mbusy = 0;

   always #5 clk = ~clk;

   mult_share_arbiter dut (
      .Clock(clk), .Reset(rst_n),
      .A_Req(a_req), .A_Q(a_q), .A_R(a_r),
      .A_Done(a_done), .A_P(a_p), .A_Err(a_err), .A_Ack(a_ack),
      .B_Req(b_req), .B_Q(b_q), .B_R(b_r),
      .B_Done(b_done), .B_P(b_p), .B_Err(b_err), .B_Ack(b_ack),
      .M_Start(m_start), .M_Q(m_q), .M_R(m_r),
      .M_P(m_p), .M_Done(m_done), .M_Ack(m_ack),
      .Busy(busy), .Last_Grant(last_g)
   );

   // Multiplier model: Done 6 cycles after Start, held until Ack.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mbusy  <= 0;
         mcnt   <= 0;
         m_done <= 0;
         m_p    <= 0;
      end else begin
         if (m_start) begin
            mbusy <= 1;
            mcnt  <= 0;
            mq_l  <= m_q;
            mr_l  <= m_r;
         end else if (mbusy) begin
            if (mcnt == 5) begin
               mbusy <= 0;
               if (!hang) begin
                  m_done <= 1;
                  m_p    <= {4'b0, mq_l} * {4'b0, mr_l};
               end
            end else begin
               mcnt <= mcnt + 1;
            end
         end
         if (m_ack && m_done) m_done <= 0;
      end
   end

   // Cycle counters for Start, Ack and WAIT-state occupancy.
   always @(negedge clk) begin
      if (m_start) n_start <= n_start + 1;
      if (m_ack) n_ack <= n_ack + 1;
      if (busy && !m_start && !m_ack && !a_done && !b_done)
         n_wait <= n_wait + 1;
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0: return a_done;
         1: return b_done;
         2: return m_start;
         default: return a_done | b_done;
      endcase
   endfunction

   task automatic wait_for(input int sel, input int maxc, input string tag);
      int n = 0;
      while (!sig(sel) && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk(tag, int'(sig(sel)), 1);
   endtask

   task automatic ack_a();
      a_ack = 1;
      a_req = 0;
      @(negedge clk);
      a_ack = 0;
      chk("a_done_drop", a_done, 0);
   endtask

   task automatic ack_b();
      b_ack = 1;
      b_req = 0;
      @(negedge clk);
      b_ack = 0;
      chk("b_done_drop", b_done, 0);
   endtask

   task automatic do_reset();
      rst_n = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
   endtask

   initial begin
      #1 rst_n = 0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_start", m_start, 0);
      chk("rst_ack", m_ack, 0);
      chk("rst_last", last_g, 1);
      chk("rst_a_done", a_done, 0);
      chk("rst_b_p", b_p, 0);
      rst_n = 1;
      @(negedge clk);

      // A alone: 3*5
      s_start = n_start; s_ack = n_ack;
      a_q = 3; a_r = 5; a_req = 1;
      wait_for(2, 10, "t1_start");
      chk("t1_mq", m_q, 3);
      chk("t1_mr", m_r, 5);
      @(negedge clk);
      chk("t1_start_pulse", m_start, 0);
      wait_for(0, 50, "t1_done");
      chk("t1_ap", a_p, 15);
      chk("t1_aerr", a_err, 0);
      chk("t1_mack_low", m_ack, 0);
      chk("t1_nstart", n_start - s_start, 1);
      chk("t1_nack", n_ack - s_ack, 2);
      repeat (3) @(negedge clk);
      chk("t1_hold", a_done, 1);
      chk("t1_b_idle", b_done, 0);
      ack_a();
      chk("t1_last", last_g, 0);
      chk("t1_ap_keep", a_p, 15);
      chk("t1_idle", busy, 0);

      // Tie after reset: A then B, then A again
      do_reset();
      a_q = 15; a_r = 15; b_q = 2; b_r = 7;
      a_req = 1; b_req = 1;
      wait_for(3, 50, "t2_first");
      chk("t2_a_first", a_done, 1);
      chk("t2_b_wait", b_done, 0);
      chk("t2_ap", a_p, 225);
      ack_a();
      wait_for(1, 50, "t2_b_done");
      chk("t2_bp", b_p, 14);
      chk("t2_berr", b_err, 0);
      ack_b();
      chk("t2_last", last_g, 1);
      a_req = 1; b_req = 1;
      wait_for(3, 50, "t2_second");
      chk("t2_a_again", a_done, 1);
      ack_a();
      wait_for(1, 50, "t2_b_again");
      ack_b();

      // Watchdog: multiplier never answers
      hang = 1;
      s_ack = n_ack; s_wait = n_wait;
      a_q = 6; a_r = 7; a_req = 1;
      wait_for(0, 80, "t3_done");
      chk("t3_err", a_err, 1);
      chk("t3_ap", a_p, 0);
      chk("t3_nwait", n_wait - s_wait, 32);
      chk("t3_nack", n_ack - s_ack, 1);
      hang = 0;
      ack_a();
      a_req = 1;
      wait_for(0, 50, "t3_next");
      chk("t3_next_p", a_p, 42);
      chk("t3_next_err", a_err, 0);
      ack_a();

      // Operand change after grant has no effect
      a_q = 4; a_r = 4; a_req = 1;
      wait_for(2, 10, "t4_start");
      a_q = 9;
      wait_for(0, 50, "t4_done");
      chk("t4_ap", a_p, 16);
      ack_a();

      // Slow Ack from A blocks B
      a_q = 2; a_r = 3; a_req = 1;
      wait_for(2, 10, "t5_start");
      b_q = 5; b_r = 5; b_req = 1;
      wait_for(0, 50, "t5_a_done");
      s_start = n_start;
      repeat (20) @(negedge clk);
      chk("t5_no_start", n_start - s_start, 0);
      chk("t5_b_blocked", b_done, 0);
      chk("t5_mq_kept", m_q, 2);
      chk("t5_a_held", a_done, 1);
      ack_a();
      chk("t5_idle_gap", m_start, 0);
      @(negedge clk);
      chk("t5_b_start", m_start, 1);
      chk("t5_b_mq", m_q, 5);
      wait_for(1, 50, "t5_b_done");
      chk("t5_bp", b_p, 25);
      ack_b();

      // Reset in WAIT
      a_q = 3; a_r = 3; a_req = 1;
      wait_for(2, 10, "t6_start");
      repeat (3) @(negedge clk);
      rst_n = 0;
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_start", m_start, 0);
      chk("t6_mack", m_ack, 0);
      chk("t6_last", last_g, 1);
      chk("t6_ap", a_p, 0);
      chk("t6_mq", m_q, 0);
      a_q = 1; a_r = 1;
      @(negedge clk);
      rst_n = 1;
      wait_for(0, 50, "t6_done");
      chk("t6_fresh_p", a_p, 1);
      chk("t6_fresh_err", a_err, 0);
      ack_a();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one shift-add 4x4 multiplier (Start/Done/Ack handshake, 8-bit product) between two requesters, A and B.
- Arbitrates round-robin, latches the winner's operands, pulses multiplier Start, waits for Done, captures the product, acks the multiplier and returns the result to the winner.
- A watchdog aborts a job whose Done never arrives.

Parameters:
- WIDTH, 4: operand width; product is 2*WIDTH.
- TIMEOUT, 32: max cycles in WAIT before abort; must be >= 2 and < 2^CNT_W.
- CNT_W, 8: watchdog counter width.

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- A_Req  in  1  requester A wants a multiply; held until A_Done
- A_Q  in  WIDTH  A multiplicand
- A_R  in  WIDTH  A multiplier
- A_Done  out  1  A result valid; held until A_Ack
- A_P  out  2*WIDTH  A product
- A_Err  out  1  A job timed out; valid with A_Done
- A_Ack  in  1  A consumed result
- B_Req, B_Q, B_R, B_Done, B_P, B_Err, B_Ack: same as A, for requester B
- M_Start  out  1  one-cycle start pulse to multiplier
- M_Q  out  WIDTH  operand to multiplier (registered)
- M_R  out  WIDTH  operand to multiplier (registered)
- M_P  in  2*WIDTH  multiplier product, valid while M_Done=1
- M_Done  in  1  multiplier finished; stays high until M_Ack
- M_Ack  out  1  acknowledge to multiplier
- Busy  out  1  state != IDLE
- Last_Grant  out  1  0 = A served last, 1 = B served last

Behaviour:
- Reset (Reset=0, async): state IDLE; all outputs 0 except Last_Grant=1, so A wins the first tie. Watchdog counter 0, grant id 0. All outputs are registered.
- States: IDLE, LAUNCH, WAIT, RELEASE, RESP.
- IDLE:
  - If only one Req=1, grant it.
  - If both, grant the requester != Last_Grant.
  - On the grant edge: latch that requester's Q/R into M_Q/M_R, store the grant id, clear the counter, go to LAUNCH.
  - If no Req, stay.
- LAUNCH (1 cycle): M_Start=1, then WAIT. M_Start is high exactly one cycle per job, on the cycle after the grant edge.
- WAIT: counter increments each cycle.
  - If M_Done=1: capture M_P into the granted X_P, X_Err=0, go to RELEASE.
  - Else if counter == TIMEOUT-1: X_P=0, X_Err=1, go to RELEASE.
  - M_Done and the timeout in the same cycle: M_Done wins, no error.
- RELEASE: M_Ack=1.
  - Normal path: M_Ack stays high until M_Done is sampled 0, then RESP.
  - Timeout path: M_Ack=1 for one cycle, then RESP.
- RESP: granted X_Done=1, with X_P/X_Err stable.
  - On X_Ack=1: X_Done drops next cycle, Last_Grant = grant id, go to IDLE.
  - Ack may arrive the same cycle Done rises.
  - X_Req state in RESP is ignored; a dropped Req does not cancel the result.
- The non-granted requester's Done, Err and P stay 0/unchanged while the other is served. Its Req waits and is evaluated at the next IDLE.
- X_P/X_Err hold their last values after Ack until overwritten by that requester's next job.
- Operand changes after the grant edge have no effect on the running job.
- X_Ack while X_Done=0 is ignored.
- Min latency, Req to X_Done: 1 (grant) + 1 (LAUNCH) + multiplier cycles + 1 (capture) + RELEASE cycles.
- Back-to-back: a new grant is possible the cycle after returning to IDLE, which avoids a combinational Req->Start path.
- Reset mid-operation: immediate return to IDLE and reset values. M_Start and M_Ack drop asynchronously. The pending job is lost and no Done is issued.

Test Plan:
- A_Req, A_Q=3, A_R=5, B idle, multiplier model with 6-cycle latency -> M_Q=3, M_R=5. M_Start pulses 1 cycle. A_P=15, A_Err=0, A_Done held until A_Ack. Last_Grant=0. M_Ack drops once M_Done is 0.
- A_Req and B_Req both high right after reset, A=(15,15), B=(2,7) -> A served first (A_P=225), then B (B_P=14). Then re-raise both -> A again, since Last_Grant=1.
- Model never raises M_Done, TIMEOUT=32 -> exactly 32 WAIT cycles, one-cycle M_Ack, A_Done=1, A_Err=1, A_P=0. Next job completes normally.
- A granted with (4,4); A_Q changed to 9 during WAIT -> A_P=16.
- A holds A_Ack=0 for 20 cycles after A_Done while B_Req=1 -> B not granted and M_Start stays 0 until A_Ack. Then B is granted on the next IDLE cycle.
- Reset asserted in WAIT -> all outputs 0 asynchronously and Last_Grant=1. After release, a fresh A request (1,1) gives A_P=1.
